// File: rtl/grf_if.sv
// Register-file access bus: two read addresses with their data, plus the write-back port.
interface grf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD;
    logic                  En;
    logic [DATA_WIDTH-1:0] BUSA;
    logic [DATA_WIDTH-1:0] BUSB;

    modport master (
        output A1, A2, A3, WD, En,
        input  BUSA, BUSB
    );

    modport slave (
        input  A1, A2, A3, WD, En,
        output BUSA, BUSB
    );
endinterface

// File: rtl/grf.sv
// MIPS general-purpose register file: $0 hardwired to zero, two combinational
// read ports that forward a same-cycle write-back, one synchronous write port.
module grf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic  clk,
    input  logic  reset,
    grf_if.slave  bus
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic                  wr_en_d;

    // $0 is never a write target, so it is also never a forwarding source.
    assign wr_en_d = bus.En && (bus.A3 != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[bus.A3] <= bus.WD;
        end
    end

    // Forwarding is deliberately not gated by reset: decode sees WD whenever a write targets it.
    always_comb begin
        bus.BUSA = '0;
        if (bus.A1 != '0) begin
            if (wr_en_d && (bus.A3 == bus.A1)) begin
                bus.BUSA = bus.WD;
            end else begin
                bus.BUSA = regs_q[bus.A1];
            end
        end
    end

    always_comb begin
        bus.BUSB = '0;
        if (bus.A2 != '0) begin
            if (wr_en_d && (bus.A3 == bus.A2)) begin
                bus.BUSB = bus.WD;
            end else begin
                bus.BUSB = regs_q[bus.A2];
            end
        end
    end
endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed scenarios plus randomized traffic
// compared against an array-based register-file model.
module tb_grf;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] model [32];

    grf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    grf #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural read value seen by decode this cycle.
    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (bus.En && bus.A3 != 5'd0 && bus.A3 == addr) return bus.WD;
        return model[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // One rising edge; the model commits the write that was presented.
    task automatic tick();
        logic        do_wr;
        logic [4:0]  a;
        logic [31:0] d;
        do_wr = !reset && bus.En && bus.A3 != 5'd0;
        a = bus.A3;
        d = bus.WD;
        @(posedge clk);
        #1;
        if (do_wr) model[a] = d;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.En = 1'b1;
        bus.A3 = a;
        bus.WD = d;
        tick();
        bus.En = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.En = 1'b0;
        bus.A3 = '0;
        bus.WD = '0;
        model_clear();
        #12;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            bus.A1 = 5'(i);
            bus.A2 = 5'(31 - i);
            #1;
            checks++;
            if (bus.BUSA !== 32'h0 || bus.BUSB !== 32'h0) begin
                errors++;
                $display("FAIL reset_zero addr=%0d BUSA=%h BUSB=%h expected 0", i, bus.BUSA, bus.BUSB);
            end
        end
    endtask

    task automatic test_zero_reg();
        bus.En = 1'b1;
        bus.A3 = 5'd0;
        bus.WD = 32'hFFFF_FFFF;
        bus.A1 = 5'd0;
        bus.A2 = 5'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.BUSA !== 32'h0 || bus.BUSB !== 32'h0) begin
                errors++;
                $display("FAIL zero_reg cycle=%0d BUSA=%h BUSB=%h expected 0", k, bus.BUSA, bus.BUSB);
            end
            tick();
        end
        bus.En = 1'b0;
    endtask

    task automatic test_write_hold();
        write_reg(5'd5, 32'h1234_5678);
        bus.A1 = 5'd5;
        bus.A2 = 5'd5;
        bus.WD = 32'hCAFE_F00D;
        #1;
        checks++;
        if (bus.BUSA !== 32'h1234_5678 || bus.BUSB !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_read BUSA=%h BUSB=%h expected 12345678", bus.BUSA, bus.BUSB);
        end
        tick();
        checks++;
        if (bus.BUSA !== 32'h1234_5678) begin
            errors++;
            $display("FAIL en0_hold BUSA=%h expected 12345678", bus.BUSA);
        end
    endtask

    task automatic test_bypass();
        write_reg(5'd7, 32'hAAAA_AAAA);
        write_reg(5'd8, 32'h0BAD_CAFE);
        bus.En = 1'b1;
        bus.A3 = 5'd7;
        bus.WD = 32'h5555_5555;
        bus.A1 = 5'd7;
        bus.A2 = 5'd8;
        #1;
        checks++;
        if (bus.BUSA !== 32'h5555_5555 || bus.BUSB !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL bypass_pre BUSA=%h BUSB=%h expected 55555555/0badcafe", bus.BUSA, bus.BUSB);
        end
        tick();
        bus.En = 1'b0;
        #1;
        checks++;
        if (bus.BUSA !== 32'h5555_5555) begin
            errors++;
            $display("FAIL bypass_post BUSA=%h expected 55555555", bus.BUSA);
        end
    endtask

    task automatic test_async_reset();
        write_reg(5'd31, 32'hDEAD_BEEF);
        bus.A1 = 5'd31;
        bus.A2 = 5'd5;
        #1;
        checks++;
        if (bus.BUSA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL pre_reset BUSA=%h expected deadbeef", bus.BUSA);
        end
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (bus.BUSA !== 32'h0 || bus.BUSB !== 32'h0) begin
            errors++;
            $display("FAIL async_reset BUSA=%h BUSB=%h expected 0", bus.BUSA, bus.BUSB);
        end
        bus.En = 1'b1;
        bus.A3 = 5'd31;
        bus.WD = 32'h1357_9BDF;
        #1;
        checks++;
        if (bus.BUSA !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL reset_bypass BUSA=%h expected 13579bdf", bus.BUSA);
        end
        tick();
        bus.En = 1'b0;
        #1;
        checks++;
        if (bus.BUSA !== 32'h0) begin
            errors++;
            $display("FAIL reset_blocks_write BUSA=%h expected 0", bus.BUSA);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_walking();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 1; i < 32; i++) begin
            bus.A1 = 5'(i);
            bus.A2 = 5'(32 - i);
            #1;
            checks++;
            if (bus.BUSA !== 32'(i) * 32'h0101_0101 || bus.BUSB !== 32'(32 - i) * 32'h0101_0101) begin
                errors++;
                $display("FAIL walking i=%0d BUSA=%h BUSB=%h expected %h/%h", i, bus.BUSA, bus.BUSB,
                         32'(i) * 32'h0101_0101, 32'(32 - i) * 32'h0101_0101);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ea;
        logic [31:0] eb;
        for (int n = 0; n < 300; n++) begin
            bus.A1 = 5'($urandom_range(0, 31));
            bus.A2 = ($urandom_range(0, 7) == 0) ? bus.A1 : 5'($urandom_range(0, 31));
            bus.A3 = ($urandom_range(0, 3) == 0) ? bus.A1 : 5'($urandom_range(0, 31));
            bus.WD = $urandom;
            bus.En = 1'($urandom_range(0, 1));
            #1;
            ea = exp_read(bus.A1);
            eb = exp_read(bus.A2);
            checks++;
            if (bus.BUSA !== ea || bus.BUSB !== eb) begin
                errors++;
                $display("FAIL random n=%0d A1=%0d A2=%0d A3=%0d En=%0b BUSA=%h BUSB=%h expected %h/%h",
                         n, bus.A1, bus.A2, bus.A3, bus.En, bus.BUSA, bus.BUSB, ea, eb);
            end
            tick();
        end
        bus.En = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.A1 = '0;
        bus.A2 = '0;
        bus.A3 = '0;
        bus.WD = '0;
        bus.En = 1'b0;
        model_clear();
        test_reset();
        test_zero_reg();
        test_write_hold();
        test_bypass();
        test_async_reset();
        test_walking();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/grf.md
Name: grf

Overview:
- General-purpose register file for the pipelined MIPS CPU.
- 32 registers × 32 bits, two combinational read ports (A1→BUSA, A2→BUSB) and one synchronous write port (A3/WD/En).
- Register $0 is hardwired to zero.
- Read ports bypass same-cycle writes, so the decode stage sees a value being written back in the same cycle.

Parameters:
- DATA_WIDTH, 32, register and data-bus width.
- ADDR_WIDTH, 5, register index width; register count = 2^ADDR_WIDTH = 32.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- A1  input  ADDR_WIDTH  read address, port A.
- A2  input  ADDR_WIDTH  read address, port B.
- A3  input  ADDR_WIDTH  write address.
- WD  input  DATA_WIDTH  write data.
- En  input  1  write enable, active-high.
- BUSA  output  DATA_WIDTH  read data for A1.
- BUSB  output  DATA_WIDTH  read data for A2.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset: reset=1 immediately forces all 32 registers to 32'h0000_0000, independent of clk.
  - While reset=1, writes are ignored.
  - Outputs reflect zeroed contents, except that the bypass path still applies (see below).
- Write: on posedge clk with reset=0, En=1 and A3≠0, reg[A3] <= WD.
  - En=0 leaves all registers unchanged.
  - A3=0 is always discarded; reg[0] stays 0 forever.
- Read: combinational, zero latency.
  - BUSA = (A1==0) ? 0 : reg[A1].
  - BUSB = (A2==0) ? 0 : reg[A2].
- Internal forwarding: if En=1, A3≠0 and A3==A1, then BUSA = WD, combinationally in the same cycle before the clock edge. BUSB follows the same rule with A2.
  - Address 0 is never forwarded; reading $0 returns 0 even if A3=0 and En=1.
- Simultaneous events:
  - A1==A2 gives identical outputs on both ports.
  - A write and a read of the same register in one cycle return the new WD (via the bypass).
  - Reset asserted mid-cycle clears registers at once; a pending write on the next edge is suppressed while reset is high.
- No X propagation: all registers have a defined value after the first reset.
  - Before the first reset, contents are unspecified.
  - Reads of $0 are always 0.
- Purely data path: no handshake, no state machine.

Test Plan:
- Reset, then sample all 32 addresses on A1/A2 -> BUSA=BUSB=0 for every address.
- Reset low, En=1, A3=0, WD=32'hFFFFFFFF for several clocks; A1=A2=0 -> BUSA=BUSB=0 (register $0 never written).
- En=1, A3=5, WD=32'h1234_5678, one edge; then En=0, A1=5, A2=5 -> BUSA=BUSB=32'h1234_5678. Change WD with En=0 -> value unchanged.
- Bypass: reg[7]=32'hAAAA_AAAA; set En=1, A3=7, WD=32'h5555_5555, A1=7, A2=8 before the edge -> BUSA=32'h5555_5555 immediately, BUSB=reg[8]. After the edge with En=0 -> BUSA=32'h5555_5555.
- Async reset: write 32'hDEAD_BEEF to reg[31]; pulse reset between clock edges -> BUSA(A1=31) drops to 0 without waiting for a clock edge. Hold reset with En=1, A3=31 across an edge -> reg[31] stays 0.
- Walking writes: write reg[i]=i*32'h0101_0101 for i=1..31; read back pairs (A1=i, A2=32-i) -> exact values, and no aliasing between registers.
